// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: data/opcode widths, opcode encodings
// and the sequencer state encoding.
package alu_pkg;
  localparam int DW  = 4;
  localparam int OCW = 3;

  localparam logic [OCW-1:0] OC_ADD = 3'b000;
  localparam logic [OCW-1:0] OC_SUB = 3'b001;
  localparam logic [OCW-1:0] OC_MUL = 3'b010;
  localparam logic [OCW-1:0] OC_DIV = 3'b011;
  localparam logic [OCW-1:0] OC_NOT = 3'b100;
  localparam logic [OCW-1:0] OC_XOR = 3'b101;
  localparam logic [OCW-1:0] OC_OR  = 3'b110;
  localparam logic [OCW-1:0] OC_AND = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic is_div0(input logic [OCW-1:0] oc, input logic [DW-1:0] b);
    return (oc == OC_DIV) && (b == '0);
  endfunction
endpackage

// File: rtl/alu.sv
// Combinational 4-bit ALU; every result is truncated mod 16.
module alu
  import alu_pkg::*;
(
  input  logic [OCW-1:0] i_oc,
  input  logic [DW-1:0]  i_a,
  input  logic [DW-1:0]  i_b,
  output logic [DW-1:0]  o_f
);
  always_comb begin
    o_f = '0;
    case (i_oc)
      OC_ADD: o_f = i_a + i_b;
      OC_SUB: o_f = i_a - i_b;
      OC_MUL: o_f = i_a * i_b;
      OC_DIV: if (i_b != '0) o_f = i_a / i_b;
      OC_NOT: o_f = ~i_a;
      OC_XOR: o_f = i_a ^ i_b;
      OC_OR:  o_f = i_a | i_b;
      OC_AND: o_f = i_a & i_b;
      default: o_f = '0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning from i_ptr upward, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);
  logic [IW:0] w_sum;

  // Scan from farthest to nearest so the candidate closest to i_ptr wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_sum = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NREQ)) w_sum = w_sum - (IW+1)'(NREQ);
      if (i_req[w_sum[IW-1:0]]) begin
        o_gnt = '0;
        o_gnt[w_sum[IW-1:0]] = 1'b1;
        o_idx = w_sum[IW-1:0];
        o_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one ALU among NREQ requesters: accept, execute,
// respond, one cycle each; operands are latched at accept.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [OCW*NREQ-1:0] req_oc,
  input  logic [DW*NREQ-1:0]  req_a,
  input  logic [DW*NREQ-1:0]  req_b,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [DW-1:0]     result,
  output logic              err,
  output logic              busy
);
  localparam int IW = $clog2(NREQ);

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_idx;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic [OCW-1:0]  r_oc;
  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;
  logic [DW-1:0]   r_result;
  logic            r_err;

  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic [OCW-1:0]  w_sel_oc;
  logic [DW-1:0]   w_sel_a;
  logic [DW-1:0]   w_sel_b;
  logic [DW-1:0]   w_f;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_comb begin
    w_sel_oc = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_oc = req_oc[i*OCW +: OCW];
        w_sel_a  = req_a[i*DW +: DW];
        w_sel_b  = req_b[i*DW +: DW];
      end
    end
  end

  // The ALU only ever sees the latched operands, never the live request buses.
  alu u_alu (
    .i_oc (r_oc),
    .i_a  (r_a),
    .i_b  (r_b),
    .o_f  (w_f)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_idx    <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_oc     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        // accept: latch the round-robin winner
        ST_IDLE: begin
          r_done <= '0;
          if (w_any) begin
            r_gnt   <= w_gnt;
            r_idx   <= w_idx;
            r_oc    <= w_sel_oc;
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_state <= ST_EXEC;
          end else begin
            r_gnt <= '0;
          end
        end
        // execute: capture result, divide-by-zero forces all-ones
        ST_EXEC: begin
          if (is_div0(r_oc, r_b)) begin
            r_result <= '1;
            r_err    <= 1'b1;
          end else begin
            r_result <= w_f;
            r_err    <= 1'b0;
          end
          r_done  <= r_gnt;
          r_state <= ST_RESP;
        end
        // respond: done visible this cycle, advance pointer past the winner
        ST_RESP: begin
          r_done  <= '0;
          r_gnt   <= '0;
          r_ptr   <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= '0;
          r_gnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt    = r_gnt;
  assign done   = r_done;
  assign result = r_result;
  assign err    = r_err;
  assign busy   = (r_state != ST_IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: stimulus pushes expected {done, result, err},
// a negedge monitor pops and compares on every done pulse.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [3*N-1:0] req_oc = '0;
  logic [4*N-1:0] req_a = '0;
  logic [4*N-1:0] req_b = '0;
  logic [N-1:0]  gnt;
  logic [N-1:0]  done;
  logic [3:0]    result;
  logic          err;
  logic          busy;

  typedef struct packed {
    logic [3:0] d;
    logic [3:0] r;
    logic       e;
  } exp_t;

  exp_t q[$];
  int n_chk  = 0;
  int n_pass = 0;

  alu_arbiter #(.NREQ(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .req_oc (req_oc),
    .req_a  (req_a),
    .req_b  (req_b),
    .gnt    (gnt),
    .done   (done),
    .result (result),
    .err    (err),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
  endtask

  task automatic set_op(input int i, input logic [2:0] oc, input logic [3:0] a, input logic [3:0] b);
    req_oc[i*3 +: 3] = oc;
    req_a[i*4 +: 4]  = a;
    req_b[i*4 +: 4]  = b;
  endtask

  task automatic push_exp(input logic [3:0] d, input logic [3:0] r, input logic e);
    exp_t x;
    x.d = d; x.r = r; x.e = e;
    q.push_back(x);
  endtask

  // Requesters drop req on their own done pulse; bounded by budget.
  task automatic run_ops(input int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || req != '0) && n < budget) begin
      @(negedge clk);
      req = req & ~done;
      n++;
    end
    if (n >= budget) chk("run_ops_timeout", 32'(q.size()) + 32'(req), 0);
  endtask

  task automatic wait_gnt(input logic [N-1:0] g, input string name);
    int n;
    n = 0;
    while (gnt !== g && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk(name, gnt, g);
  endtask

  // Monitor: every done pulse is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      chk("done_onehot0", 32'($onehot0(done)), 1);
      if (done != '0) begin
        if (q.size() == 0) begin
          chk("unexpected_done", done, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_vec", done, e.d);
          chk("result", result, e.r);
          chk("err", err, e.e);
          chk("gnt_eq_done", gnt, done);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, nd, k, n3;
    logic [3:0] sweep_exp [8];
    sweep_exp = '{4'h9, 4'h3, 4'h2, 4'h2, 4'h9, 4'h5, 4'h7, 4'h2};

    // reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: single ADD 9+8 -> 1
    @(posedge clk); #1;
    set_op(0, OC_ADD, 4'd9, 4'd8);
    req = 4'b0001;
    push_exp(4'b0001, 4'h1, 1'b0);
    @(negedge clk);
    chk("t1_gnt_before_accept", gnt, 0);
    @(negedge clk);
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_busy", busy, 1);
    run_ops(20);

    // 5: reset during EXEC discards the op (ptr was 1 here)
    @(posedge clk); #1;
    set_op(1, OC_ADD, 4'd2, 4'd3);
    req = 4'b0010;
    wait_gnt(4'b0010, "t5_gnt");
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    chk("t5_gnt", gnt, 0);
    chk("t5_done", done, 0);
    chk("t5_busy", busy, 0);
    chk("t5_result", result, 0);
    chk("t5_err", err, 0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_done", done, 0);
    end

    // 2: all four at once with ptr=0 -> order 0,1,2,3 on cycles 2,5,8,11
    @(posedge clk); #1;
    set_op(0, OC_ADD, 4'd1, 4'd2);
    set_op(1, OC_SUB, 4'd3, 4'd5);
    set_op(2, OC_MUL, 4'd7, 4'd3);
    set_op(3, OC_OR,  4'd8, 4'd1);
    push_exp(4'b0001, 4'h3, 1'b0);
    push_exp(4'b0010, 4'hE, 1'b0);
    push_exp(4'b0100, 4'h5, 1'b0);
    push_exp(4'b1000, 4'h9, 1'b0);
    req = 4'b1111;
    c = 0;
    nd = 0;
    while (nd < 4 && c < 40) begin
      @(negedge clk);
      if (done != '0) begin
        chk("t2_done_cycle", c, 2 + 3 * nd);
        nd++;
      end
      req = req & ~done;
      c++;
    end
    if (nd < 4) chk("t2_timeout", nd, 4);

    // 3: DIV by zero then a normal DIV
    set_op(2, OC_DIV, 4'd7, 4'd0);
    push_exp(4'b0100, 4'hF, 1'b1);
    req = 4'b0100;
    run_ops(20);
    set_op(2, OC_DIV, 4'd7, 4'd2);
    push_exp(4'b0100, 4'h3, 1'b0);
    req = 4'b0100;
    run_ops(20);

    // 4: requester drops req and changes a during EXEC; latched 5-7 -> E
    set_op(1, OC_SUB, 4'd5, 4'd7);
    push_exp(4'b0010, 4'hE, 1'b0);
    req = 4'b0010;
    wait_gnt(4'b0010, "t4_gnt");
    req = '0;
    req_a[7:4] = 4'd0;
    run_ops(20);

    // 6: opcode sweep on req[0] (a=6,b=3) while req[3] stays high; ptr reset to 0
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    set_op(0, OC_ADD, 4'd6, 4'd3);
    set_op(3, OC_AND, 4'hF, 4'h5);
    for (int i = 0; i < 8; i++) begin
      push_exp(4'b0001, sweep_exp[i], 1'b0);
      push_exp(4'b1000, 4'h5, 1'b0);
    end
    req = 4'b1001;
    k = 0;
    n3 = 0;
    c = 0;
    while ((q.size() != 0 || req != '0) && c < 200) begin
      @(negedge clk);
      if (done[0]) begin
        k++;
        if (k < 8) req_oc[2:0] = 3'(k);
        else req[0] = 1'b0;
      end
      if (done[3]) begin
        n3++;
        if (n3 == 8) req[3] = 1'b0;
      end
      c++;
    end
    if (c >= 200) chk("t6_timeout", 32'(q.size()), 0);
    repeat (4) @(negedge clk);
    chk("end_idle_busy", busy, 0);
    chk("end_queue_empty", 32'(q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
